pipelined_control_unit: RTL and testbench

Parametrised successor to the single-cycle MIPS controller. It decodes opcode/funct in ID and carries the resulting control bundle through ID/EX, EX/MEM and MEM/WB registers. It also handles hazard bubbles, branch flushes and a multi-cycle mult/div sequencer that stalls the front end. It sits between the IF/ID register and the datapath stage muxes and replaces the per-stage control plumbing in the pipeline top.

---
 rtl/pipelined_control_unit.sv | 205 ++++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// Pipelined MIPS control unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control
// registers, bubble/flush handling and a multi-cycle mult/div sequencer.
module pipelined_control_unit #(
  parameter int unsigned ALU_CTRL_W     = 3,
  parameter int unsigned MULDIV_CYCLES  = 4,
  parameter int unsigned SUPPORT_MULDIV = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  id_valid,
  input  logic                  stall_in,
  input  logic                  flush_ex,
  output logic                  id_jump,
  output logic                  illegal_op,
  output logic                  stall_out,
  output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
  output logic                  ex_alu_src_sel,
  output logic                  ex_reg_file_dst_sel,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  ex_muldiv_start,
  output logic                  muldiv_busy,
  output logic                  mem_mem_wr_en,
  output logic                  mem_mem_to_reg_wr,
  output logic                  mem_reg_wr_en,
  output logic                  wb_mem_to_reg_wr,
  output logic                  wb_reg_wr_en,
  output logic                  muldiv_done
);

  localparam int unsigned CNT_W = $clog2(MULDIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 2);

  typedef struct packed {
    logic                  valid;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  alu_src;
    logic                  reg_dst;
    logic                  branch;
    logic                  jump;
    logic                  mem_wr;
    logic                  mem_to_reg;
    logic                  reg_wr;
    logic                  muldiv;
  } ctrl_t;

  typedef struct packed {
    logic mem_wr;
    logic mem_to_reg;
    logic reg_wr;
  } mem_ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_wr;
  } wb_ctrl_t;

  typedef enum logic {IDLE, BUSY} state_t;

  ctrl_t      dec;
  logic       unknown;
  ctrl_t      id_ex_q, id_ex_d;
  mem_ctrl_t  ex_mem_q, ex_mem_d;
  wb_ctrl_t   mem_wb_q;
  state_t     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic       seq_last;

  // Opcode/funct decode; unknown or invalid slots collapse to the NOP bundle
  always_comb begin
    dec     = '0;
    unknown = 1'b0;
    case (opcode)
      6'b000000: begin
        dec.valid   = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.reg_dst = 1'b1;
        case (funct)
          6'b100000: dec.alu_ctrl = ALU_CTRL_W'(3'b010);
          6'b100010: dec.alu_ctrl = ALU_CTRL_W'(3'b110);
          6'b100100: dec.alu_ctrl = ALU_CTRL_W'(3'b000);
          6'b100101: dec.alu_ctrl = ALU_CTRL_W'(3'b001);
          6'b101010: dec.alu_ctrl = ALU_CTRL_W'(3'b111);
          6'b011000, 6'b011010: begin
            dec.reg_wr  = 1'b0;
            dec.reg_dst = 1'b0;
            dec.muldiv  = 1'b1;
            unknown     = (SUPPORT_MULDIV == 0);
          end
          default: unknown = 1'b1;
        endcase
      end
      6'b100011: begin
        dec.valid      = 1'b1;
        dec.reg_wr     = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_ctrl   = ALU_CTRL_W'(3'b010);
      end
      6'b101011: begin
        dec.valid    = 1'b1;
        dec.mem_wr   = 1'b1;
        dec.alu_src  = 1'b1;
        dec.alu_ctrl = ALU_CTRL_W'(3'b010);
      end
      6'b000100: begin
        dec.valid    = 1'b1;
        dec.branch   = 1'b1;
        dec.alu_ctrl = ALU_CTRL_W'(3'b110);
      end
      6'b001000: begin
        dec.valid    = 1'b1;
        dec.reg_wr   = 1'b1;
        dec.alu_src  = 1'b1;
        dec.alu_ctrl = ALU_CTRL_W'(3'b010);
      end
      6'b000010: begin
        dec.valid = 1'b1;
        dec.jump  = 1'b1;
      end
      default: unknown = 1'b1;
    endcase
    if (!id_valid || unknown) dec = '0;
  end

  assign illegal_op = id_valid & unknown;
  assign id_jump    = dec.jump;

  // Sequencer status derived from registered state only (plus flush abort)
  assign ex_muldiv_start = (state_q == IDLE) & id_ex_q.valid & id_ex_q.muldiv;
  assign muldiv_busy     = (state_q == BUSY) | ex_muldiv_start;
  assign seq_last        = (state_q == BUSY) & (cnt_q == '0);
  assign muldiv_done     = seq_last & ~flush_ex;
  assign stall_out       = stall_in | muldiv_busy;

  // Mult/div sequencer: counts EX occupancy, flush aborts silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (flush_ex) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ex_muldiv_start) begin
            state_q <= BUSY;
            cnt_q   <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Stage next-state: flush > hold for mult/div > bubble > decode
  always_comb begin
    id_ex_d  = dec;
    ex_mem_d = '0;
    if (flush_ex)                     id_ex_d = '0;
    else if (muldiv_busy && !seq_last) id_ex_d = id_ex_q;
    else if (stall_in || !id_valid)   id_ex_d = '0;
    if (!muldiv_busy && !id_ex_q.muldiv) begin
      ex_mem_d.mem_wr     = id_ex_q.mem_wr;
      ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
      ex_mem_d.reg_wr     = id_ex_q.reg_wr;
    end
  end

  // Pipeline control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q             <= id_ex_d;
      ex_mem_q            <= ex_mem_d;
      mem_wb_q.mem_to_reg <= ex_mem_q.mem_to_reg;
      mem_wb_q.reg_wr     <= ex_mem_q.reg_wr;
    end
  end

  assign ex_alu_ctrl         = id_ex_q.alu_ctrl;
  assign ex_alu_src_sel      = id_ex_q.alu_src;
  assign ex_reg_file_dst_sel = id_ex_q.reg_dst;
  assign ex_branch           = id_ex_q.branch;
  assign ex_jump             = id_ex_q.jump;
  assign mem_mem_wr_en       = ex_mem_q.mem_wr;
  assign mem_mem_to_reg_wr   = ex_mem_q.mem_to_reg;
  assign mem_reg_wr_en       = ex_mem_q.reg_wr;
  assign wb_mem_to_reg_wr    = mem_wb_q.mem_to_reg;
  assign wb_reg_wr_en        = mem_wb_q.reg_wr;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed instruction stream with a
// per-cycle reference model plus hand-computed spot checks.
module tb_pipelined_control_unit;

  localparam int MC = 4;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000, F_MULT = 6'b011000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic id_valid = 1'b0, stall_in = 1'b0, flush_ex = 1'b0;

  logic id_jump, illegal_op, stall_out, ex_alu_src_sel, ex_reg_file_dst_sel;
  logic ex_branch, ex_jump, ex_muldiv_start, muldiv_busy, mem_mem_wr_en;
  logic mem_mem_to_reg_wr, mem_reg_wr_en, wb_mem_to_reg_wr, wb_reg_wr_en, muldiv_done;
  logic [2:0] ex_alu_ctrl;

  logic b_id_jump, b_illegal_op, b_stall_out, b_ex_alu_src_sel, b_ex_reg_file_dst_sel;
  logic b_ex_branch, b_ex_jump, b_ex_muldiv_start, b_muldiv_busy, b_mem_mem_wr_en;
  logic b_mem_mem_to_reg_wr, b_mem_reg_wr_en, b_wb_mem_to_reg_wr, b_wb_reg_wr_en, b_muldiv_done;
  logic [2:0] b_ex_alu_ctrl;

  int total = 0;
  int passed = 0;

  pipelined_control_unit #(.ALU_CTRL_W(3), .MULDIV_CYCLES(MC), .SUPPORT_MULDIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .id_valid(id_valid),
    .stall_in(stall_in), .flush_ex(flush_ex), .id_jump(id_jump), .illegal_op(illegal_op),
    .stall_out(stall_out), .ex_alu_ctrl(ex_alu_ctrl), .ex_alu_src_sel(ex_alu_src_sel),
    .ex_reg_file_dst_sel(ex_reg_file_dst_sel), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_muldiv_start(ex_muldiv_start), .muldiv_busy(muldiv_busy),
    .mem_mem_wr_en(mem_mem_wr_en), .mem_mem_to_reg_wr(mem_mem_to_reg_wr),
    .mem_reg_wr_en(mem_reg_wr_en), .wb_mem_to_reg_wr(wb_mem_to_reg_wr),
    .wb_reg_wr_en(wb_reg_wr_en), .muldiv_done(muldiv_done));

  pipelined_control_unit #(.ALU_CTRL_W(3), .MULDIV_CYCLES(MC), .SUPPORT_MULDIV(0)) dut_nomd (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .id_valid(id_valid),
    .stall_in(stall_in), .flush_ex(flush_ex), .id_jump(b_id_jump), .illegal_op(b_illegal_op),
    .stall_out(b_stall_out), .ex_alu_ctrl(b_ex_alu_ctrl), .ex_alu_src_sel(b_ex_alu_src_sel),
    .ex_reg_file_dst_sel(b_ex_reg_file_dst_sel), .ex_branch(b_ex_branch), .ex_jump(b_ex_jump),
    .ex_muldiv_start(b_ex_muldiv_start), .muldiv_busy(b_muldiv_busy),
    .mem_mem_wr_en(b_mem_mem_wr_en), .mem_mem_to_reg_wr(b_mem_mem_to_reg_wr),
    .mem_reg_wr_en(b_mem_reg_wr_en), .wb_mem_to_reg_wr(b_wb_mem_to_reg_wr),
    .wb_reg_wr_en(b_wb_reg_wr_en), .muldiv_done(b_muldiv_done));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: control bundle as plain fields, sequencer as remaining-cycle count
  typedef struct {
    bit v; int alu; bit src, dst, br, jmp, mw, m2r, rw, md, ill;
  } mb_t;

  int fn_code[5] = '{32, 34, 36, 37, 42};
  int fn_alu[5]  = '{2, 6, 0, 1, 7};

  function automatic mb_t mdec(input logic [5:0] op, input logic [5:0] fn,
                               input logic valid, input bit sup);
    mb_t r;
    bit ill;
    r = '{default: 0};
    r.v = 1;
    case (int'(op))
      0: begin
        r.ill = 1;
        foreach (fn_code[i])
          if (int'(fn) == fn_code[i]) begin
            r.ill = 0; r.alu = fn_alu[i]; r.rw = 1; r.dst = 1;
          end
        if ((int'(fn) == 24 || int'(fn) == 26) && sup) begin r.ill = 0; r.md = 1; end
      end
      35: begin r.rw = 1; r.src = 1; r.m2r = 1; r.alu = 2; end
      43: begin r.mw = 1; r.src = 1; r.alu = 2; end
      4:  begin r.br = 1; r.alu = 6; end
      8:  begin r.rw = 1; r.src = 1; r.alu = 2; end
      2:  r.jmp = 1;
      default: r.ill = 1;
    endcase
    if (!valid || r.ill) begin
      ill = valid && r.ill;
      r = '{default: 0};
      r.ill = ill;
    end
    return r;
  endfunction

  mb_t m_ex, m_mem, m_wb, bub;
  int  m_left;

  // Per-cycle compare against the model, then advance the model
  always @(negedge clk) begin
    mb_t d, db;
    bit start, busy, done;
    int rem;
    bub = '{default: 0};
    if (!rst_n) begin
      m_ex = bub; m_mem = bub; m_wb = bub; m_left = 0;
    end
    d     = mdec(opcode, funct, id_valid, 1'b1);
    db    = mdec(opcode, funct, id_valid, 1'b0);
    start = (m_left == 0) && m_ex.md;
    rem   = start ? MC : m_left;
    busy  = rem > 0;
    done  = busy && rem == 1 && !flush_ex;

    chk("id_jump", 32'(id_jump), 32'(d.jmp));
    chk("illegal_op", 32'(illegal_op), 32'(d.ill));
    chk("stall_out", 32'(stall_out), 32'(stall_in | busy));
    chk("ex_alu_ctrl", 32'(ex_alu_ctrl), 32'(m_ex.alu));
    chk("ex_alu_src_sel", 32'(ex_alu_src_sel), 32'(m_ex.src));
    chk("ex_reg_file_dst_sel", 32'(ex_reg_file_dst_sel), 32'(m_ex.dst));
    chk("ex_branch", 32'(ex_branch), 32'(m_ex.br));
    chk("ex_jump", 32'(ex_jump), 32'(m_ex.jmp));
    chk("ex_muldiv_start", 32'(ex_muldiv_start), 32'(start));
    chk("muldiv_busy", 32'(muldiv_busy), 32'(busy));
    chk("muldiv_done", 32'(muldiv_done), 32'(done));
    chk("mem_mem_wr_en", 32'(mem_mem_wr_en), 32'(m_mem.mw));
    chk("mem_mem_to_reg_wr", 32'(mem_mem_to_reg_wr), 32'(m_mem.m2r));
    chk("mem_reg_wr_en", 32'(mem_reg_wr_en), 32'(m_mem.rw));
    chk("wb_mem_to_reg_wr", 32'(wb_mem_to_reg_wr), 32'(m_wb.m2r));
    chk("wb_reg_wr_en", 32'(wb_reg_wr_en), 32'(m_wb.rw));
    chk("nomd_illegal_op", 32'(b_illegal_op), 32'(db.ill));
    chk("nomd_muldiv_busy", 32'(b_muldiv_busy), 32'd0);

    if (rst_n) begin
      m_wb  = m_mem;
      m_mem = (busy || m_ex.md) ? bub : m_ex;
      if (flush_ex)                       m_ex = bub;
      else if (busy && rem != 1)          m_ex = m_ex;
      else if (stall_in || !id_valid)     m_ex = bub;
      else                                m_ex = d;
      m_left = flush_ex ? 0 : (busy ? rem - 1 : 0);
    end
  end

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic v,
                       input logic st, input logic fl);
    opcode = op; funct = fn; id_valid = v; stall_in = st; flush_ex = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst ex_alu_ctrl", 32'(ex_alu_ctrl), 32'd0);
    chk("rst wb_reg_wr_en", 32'(wb_reg_wr_en), 32'd0);
    chk("rst muldiv_busy", 32'(muldiv_busy), 32'd0);
    rst_n = 1'b1;

    // lw, sw, add, beq, j stream
    drive(OP_LW, 6'd0, 1, 0, 0);   tick();
    chk("lw ex_alu_ctrl", 32'(ex_alu_ctrl), 32'd2);
    chk("lw ex_alu_src", 32'(ex_alu_src_sel), 32'd1);
    drive(OP_SW, 6'd0, 1, 0, 0);   tick();
    chk("sw ex_alu_ctrl", 32'(ex_alu_ctrl), 32'd2);
    drive(OP_R, F_ADD, 1, 0, 0);   tick();
    chk("add ex_alu_ctrl", 32'(ex_alu_ctrl), 32'd2);
    chk("add ex_dst", 32'(ex_reg_file_dst_sel), 32'd1);
    chk("lw wb_reg_wr_en", 32'(wb_reg_wr_en), 32'd1);
    drive(OP_BEQ, 6'd0, 1, 0, 0);  tick();
    chk("beq ex_alu_ctrl", 32'(ex_alu_ctrl), 32'd6);
    chk("beq ex_branch", 32'(ex_branch), 32'd1);
    chk("sw wb_reg_wr_en", 32'(wb_reg_wr_en), 32'd0);
    drive(OP_J, 6'd0, 1, 0, 0);
    #1 chk("j id_jump", 32'(id_jump), 32'd1);
    tick();
    chk("j ex_jump", 32'(ex_jump), 32'd1);
    chk("add wb_reg_wr_en", 32'(wb_reg_wr_en), 32'd1);

    // load-use stall inserts one bubble
    drive(OP_LW, 6'd0, 1, 0, 0);   tick();
    drive(OP_R, F_ADD, 1, 1, 0);   tick();
    chk("stall bubble alu", 32'(ex_alu_ctrl), 32'd0);
    chk("stall bubble src", 32'(ex_alu_src_sel), 32'd0);
    drive(OP_R, F_ADD, 1, 0, 0);   tick();
    chk("late add dst", 32'(ex_reg_file_dst_sel), 32'd1);
    drive(6'd0, 6'd0, 0, 0, 0);    tick();

    // mult occupies EX for four cycles
    drive(OP_R, F_MULT, 1, 0, 0);  tick();
    chk("mult c0 start", 32'(ex_muldiv_start), 32'd1);
    chk("mult c0 stall_out", 32'(stall_out), 32'd1);
    drive(OP_ADDI, 6'd0, 1, 0, 0); tick();
    chk("mult c1 start", 32'(ex_muldiv_start), 32'd0);
    chk("mult c1 stall_out", 32'(stall_out), 32'd1);
    tick();
    chk("mult c2 done", 32'(muldiv_done), 32'd0);
    tick();
    chk("mult c3 done", 32'(muldiv_done), 32'd1);
    chk("mult c3 mem_reg_wr", 32'(mem_reg_wr_en), 32'd0);
    tick();
    chk("mult c4 stall_out", 32'(stall_out), 32'd0);
    chk("addi ex_alu_ctrl", 32'(ex_alu_ctrl), 32'd2);
    chk("addi ex_alu_src", 32'(ex_alu_src_sel), 32'd1);
    drive(6'd0, 6'd0, 0, 0, 0);    tick();

    // flush during BUSY at cnt=1
    drive(OP_R, F_MULT, 1, 0, 0);  tick();
    drive(6'd0, 6'd0, 0, 0, 0);    tick();
    tick();
    drive(6'd0, 6'd0, 0, 0, 1);
    #1 chk("flush no done", 32'(muldiv_done), 32'd0);
    tick();
    chk("flush busy", 32'(muldiv_busy), 32'd0);
    chk("flush stall_out", 32'(stall_out), 32'd0);
    drive(6'd0, 6'd0, 0, 0, 0);    tick();
    chk("flush late done", 32'(muldiv_done), 32'd0);

    // flush beats stall; plain flush kills add
    drive(OP_R, F_ADD, 1, 1, 1);   tick();
    chk("flush+stall dst", 32'(ex_reg_file_dst_sel), 32'd0);
    drive(OP_R, F_ADD, 1, 0, 1);   tick();
    chk("flush dst", 32'(ex_reg_file_dst_sel), 32'd0);
    drive(OP_R, F_ADD, 1, 0, 0);   tick();
    chk("post-flush dst", 32'(ex_reg_file_dst_sel), 32'd1);

    // illegal encodings
    drive(6'b111111, 6'd0, 1, 0, 0);
    #1 chk("bad opcode illegal", 32'(illegal_op), 32'd1);
    tick();
    chk("bad opcode nop", 32'(ex_reg_file_dst_sel), 32'd0);
    drive(OP_R, 6'b000001, 1, 0, 0);
    #1 chk("bad funct illegal", 32'(illegal_op), 32'd1);
    tick();
    chk("bad funct nop", 32'(ex_reg_file_dst_sel), 32'd0);
    drive(6'b111111, 6'd0, 0, 0, 0);
    #1 chk("invalid not illegal", 32'(illegal_op), 32'd0);
    drive(OP_R, F_MULT, 1, 0, 0);
    #1 chk("mult legal", 32'(illegal_op), 32'd0);
    chk("nomd mult illegal", 32'(b_illegal_op), 32'd1);
    tick();
    chk("nomd no start", 32'(b_ex_muldiv_start), 32'd0);
    drive(6'd0, 6'd0, 0, 0, 0);
    repeat (5) tick();

    // asynchronous reset while BUSY
    drive(OP_R, F_MULT, 1, 0, 0);  tick();
    drive(6'd0, 6'd0, 0, 0, 0);    tick();
    rst_n = 1'b0;
    #1;
    chk("arst busy", 32'(muldiv_busy), 32'd0);
    chk("arst stall_out", 32'(stall_out), 32'd0);
    chk("arst done", 32'(muldiv_done), 32'd0);
    chk("arst ex_alu_ctrl", 32'(ex_alu_ctrl), 32'd0);
    chk("arst mem_reg_wr", 32'(mem_reg_wr_en), 32'd0);
    tick();
    rst_n = 1'b1;
    drive(OP_R, F_ADD, 1, 0, 0);   tick();
    chk("post-rst add dst", 32'(ex_reg_file_dst_sel), 32'd1);
    drive(6'd0, 6'd0, 0, 0, 0);
    repeat (4) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
